// File: rtl/div_vec3.sv
// Element-wise signed fixed-point vec3 divider: three radix-2 restoring lanes
// share one IDLE/CALC/DONE controller, with saturation and divide-by-zero flags.
module div_vec3 #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0][WIDTH-1:0] din_a,
    input  logic [2:0][WIDTH-1:0] din_b,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [2:0][WIDTH-1:0] dout,
    output logic [2:0]            dout_div0,
    output logic                  dout_valid
);

    localparam int QBITS = WIDTH + FRAC;
    localparam int CW    = $clog2(QBITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [2:0]                  sign_q, sign_d;
    logic [2:0]                  div0_q, div0_d;
    logic [2:0][WIDTH-1:0]       den_q, den_d;
    logic [2:0][WIDTH-1:0]       rem_q, rem_d;
    logic [2:0][QBITS-1:0]       quo_q, quo_d;
    logic [2:0][WIDTH-1:0]       dout_q, dout_d;
    logic [2:0]                  flag_q, flag_d;
    logic                        valid_q, valid_d;

    logic [2:0][WIDTH-1:0]       abs_a, abs_b;
    logic [2:0][WIDTH:0]         rem_sh, trial;
    logic [2:0][WIDTH-1:0]       mag, res;

    assign din_ready  = (state_q == S_IDLE);
    assign dout       = dout_q;
    assign dout_div0  = flag_q;
    assign dout_valid = valid_q;

    // Per-lane datapath: operand magnitudes, one restoring step, final result.
    // The quotient register starts holding the dividend; its MSB feeds the
    // remainder while quotient bits shift in at the LSB.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            abs_a[i]  = din_a[i][WIDTH-1] ? (~din_a[i] + WIDTH'(1)) : din_a[i];
            abs_b[i]  = din_b[i][WIDTH-1] ? (~din_b[i] + WIDTH'(1)) : din_b[i];
            rem_sh[i] = {rem_q[i], quo_q[i][QBITS-1]};
            trial[i]  = rem_sh[i] - {1'b0, den_q[i]};
            if (div0_q[i] || (|quo_q[i][QBITS-1:WIDTH-1]))
                mag[i] = MAX_MAG;
            else
                mag[i] = quo_q[i][WIDTH-1:0];
            res[i] = sign_q[i] ? (~mag[i] + WIDTH'(1)) : mag[i];
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        div0_d  = div0_q;
        den_d   = den_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dout_d  = dout_q;
        flag_d  = flag_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        div0_d[i] = (din_b[i] == '0);
                        // A div0 lane saturates toward the numerator's sign.
                        sign_d[i] = div0_d[i] ? din_a[i][WIDTH-1]
                                              : (din_a[i][WIDTH-1] ^ din_b[i][WIDTH-1]);
                        den_d[i]  = abs_b[i];
                        rem_d[i]  = '0;
                        quo_d[i]  = {abs_a[i], {FRAC{1'b0}}};
                    end
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                for (int i = 0; i < 3; i++) begin
                    rem_d[i] = trial[i][WIDTH] ? rem_sh[i][WIDTH-1:0] : trial[i][WIDTH-1:0];
                    quo_d[i] = {quo_q[i][QBITS-2:0], ~trial[i][WIDTH]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QBITS - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                dout_d  = res;
                flag_d  = div0_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= '0;
            div0_q  <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dout_q  <= '0;
            flag_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            div0_q  <= div0_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dout_q  <= dout_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_div_vec3.sv
// Scoreboard bench for div_vec3: expected quotients come from an integer
// model of the fixed-point division and are matched against each dout pulse.
module tb_div_vec3;

    localparam int W   = 24;
    localparam int LAT = 37;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [2:0][W-1:0]   din_a = '0;
    logic [2:0][W-1:0]   din_b = '0;
    logic                din_valid = 1'b0;
    logic                din_ready;
    logic [2:0][W-1:0]   dout;
    logic [2:0]          dout_div0;
    logic                dout_valid;

    typedef struct {
        logic [2:0][W-1:0] q;
        logic [2:0]        d0;
        int                acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    div_vec3 #(.WIDTH(24), .FRAC(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_a      (din_a),
        .din_b      (din_b),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_div0  (dout_div0),
        .dout_valid (dout_valid)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: floor(|a|*4096/|b|), clamped symmetrically, sign applied.
    function automatic void lane_model(input logic [W-1:0] a_u, input logic [W-1:0] b_u,
                                       output logic [W-1:0] q, output logic d0);
        longint la, lb, ma, mb, mag, r;
        bit     neg;
        la = longint'($signed(a_u));
        lb = longint'($signed(b_u));
        ma = (la < 0) ? -la : la;
        mb = (lb < 0) ? -lb : lb;
        if (lb == 0) begin
            mag = 64'd8388607;
            neg = (la < 0);
            d0  = 1'b1;
        end else begin
            mag = (ma * 4096) / mb;
            if (mag > 8388607) mag = 8388607;
            neg = (la < 0) != (lb < 0);
            d0  = 1'b0;
        end
        r = neg ? -mag : mag;
        q = r[W-1:0];
    endfunction

    function automatic exp_t vec_model(input logic [2:0][W-1:0] a, input logic [2:0][W-1:0] b,
                                       input int acc);
        exp_t e;
        for (int i = 0; i < 3; i++) lane_model(a[i], b[i], e.q[i], e.d0[i]);
        e.acc = acc;
        return e;
    endfunction

    task automatic do_op(input logic [2:0][W-1:0] a, input logic [2:0][W-1:0] b,
                         output int acc);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_wait", {71'd0, ok}, 72'd1);
        din_a     = a;
        din_b     = b;
        din_valid = 1'b1;
        acc       = cyc + 1;
        sb.push_back(vec_model(a, b, acc));
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        check("drain", 72'(sb.size()), 72'd0);
    endtask

    // Output monitor: pops one expectation per pulse, and checks dout holds between pulses.
    initial begin
        exp_t              e;
        logic [2:0][W-1:0] last_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_dout = dout;
            end else if (dout_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 72'd1, 72'd0);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.q);
                    check("div0", 72'(dout_div0), 72'(e.d0));
                    check("latency", 72'(cyc - e.acc), 72'(LAT));
                end
                last_dout = dout;
            end else begin
                check("hold", dout, last_dout);
            end
        end
    end

    initial begin
        int                acc0, acc1, busy;
        logic [2:0][W-1:0] a, b;

        #1;
        check("rst_dout", dout, 72'd0);
        check("rst_div0", 72'(dout_div0), 72'd0);
        check("rst_valid", 72'(dout_valid), 72'd0);
        check("rst_ready", 72'(din_ready), 72'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Lane order is {z, y, x}: index 0 is x.
        do_op({24'sd4096, -24'sd12288, 24'sd24576}, {24'sd12288, 24'sd6144, 24'sd8192}, acc0);
        do_op({24'sd20480, 24'sd0, -24'sd4096}, {24'sd8192, 24'sd0, 24'sd0}, acc0);
        do_op({-24'sd1, -24'sd4096000, 24'sd4096000}, {24'sd8192, 24'sd4, 24'sd4}, acc0);
        do_op({-24'sd8388608, 24'sd4096, -24'sd4096}, {-24'sd4096, -24'sd16384, -24'sd16384}, acc0);
        do_op({24'sd0, 24'sd12288, -24'sd8388608}, {24'sd5, 24'sd8192, 24'sd8192}, acc0);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 3; i++) begin
                a[i] = W'($urandom);
                b[i] = W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 300) : $urandom);
            end
            do_op(a, b, acc0);
        end
        drain();

        // Continuous valid with a fresh vector every cycle.
        busy = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                din_a[i] = W'($urandom);
                din_b[i] = W'($urandom);
            end
            din_valid = 1'b1;
            check("ready_busy", 72'(din_ready), 72'(busy == 0));
            if (busy == 0) begin
                sb.push_back(vec_model(din_a, din_b, cyc + 1));
                busy = LAT;
            end else begin
                busy--;
            end
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        drain();

        // Back-to-back accepts.
        do_op({24'sd100, 24'sd7, -24'sd40960}, {24'sd3, -24'sd9, 24'sd4096}, acc0);
        do_op({24'sd8191, -24'sd1, 24'sd1}, {24'sd2, 24'sd3, -24'sd1}, acc1);
        check("spacing", 72'(acc1 - acc0), 72'(LAT + 1));
        drain();

        // Asynchronous reset in the middle of CALC.
        do_op({24'sd4096, 24'sd4096, 24'sd4096}, {24'sd3, 24'sd3, 24'sd3}, acc0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_dout", dout, 72'd0);
        check("mid_rst_div0", 72'(dout_div0), 72'd0);
        check("mid_rst_valid", 72'(dout_valid), 72'd0);
        check("mid_rst_ready", 72'(din_ready), 72'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (45) @(negedge clk);
        check("post_rst_ready", 72'(din_ready), 72'd1);
        do_op({24'sd0, -24'sd8192, 24'sd12288}, {24'sd4096, 24'sd4096, 24'sd8192}, acc0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
